// File: rtl/sys_array_sequencer_if.sv
// Host/fetcher-side bundle of the systolic-array run sequencer.
// First-mismatch capture signals exist only with SEQ_FIRST_ERR_EN.
interface sys_array_sequencer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int RES_ROWS   = 2,
  parameter int RES_COLS   = 2
);
  localparam int RW = (RES_ROWS > 1) ? $clog2(RES_ROWS) : 1;
  localparam int CW = (RES_COLS > 1) ? $clog2(RES_COLS) : 1;
  localparam int RDW = 2 * DATA_WIDTH;

  logic           go;
  logic           abort;
  logic           load_params;
  logic           start_comp;
  logic           ready;
  logic [RW-1:0]  res_row;
  logic [CW-1:0]  res_col;
  logic [RDW-1:0] res_data;
  logic [RDW-1:0] exp_data;
  logic           busy;
  logic           done;
  logic           pass;
  logic [7:0]     err_count;
  logic           timeout;
`ifdef SEQ_FIRST_ERR_EN
  logic           first_err_valid;
  logic [RW-1:0]  first_err_row;
  logic [CW-1:0]  first_err_col;
  logic [RDW-1:0] first_err_data;

  modport slave (
    input  go, abort, ready, res_data, exp_data,
    output load_params, start_comp, res_row, res_col,
    output busy, done, pass, err_count, timeout,
    output first_err_valid, first_err_row,
    output first_err_col, first_err_data
  );
  modport master (
    output go, abort, ready, res_data, exp_data,
    input  load_params, start_comp, res_row, res_col,
    input  busy, done, pass, err_count, timeout,
    input  first_err_valid, first_err_row,
    input  first_err_col, first_err_data
  );
`else
  modport slave (
    input  go, abort, ready, res_data, exp_data,
    output load_params, start_comp, res_row, res_col,
    output busy, done, pass, err_count, timeout
  );
  modport master (
    output go, abort, ready, res_data, exp_data,
    input  load_params, start_comp, res_row, res_col,
    input  busy, done, pass, err_count, timeout
  );
`endif
endinterface

// File: rtl/sys_array_sequencer.sv
// One-shot run controller: load, start, wait, then check every result.
// Optional first-mismatch capture is enabled by SEQ_FIRST_ERR_EN.
module sys_array_sequencer #(
  parameter int DATA_WIDTH  = 8,
  parameter int RES_ROWS    = 2,
  parameter int RES_COLS    = 2,
  parameter int LOAD_CYCLES = 4,
  parameter int TIMEOUT     = 1023
) (
  input logic clk,
  input logic reset_n,
  sys_array_sequencer_if.slave bus
);
  localparam int RW = (RES_ROWS > 1) ? $clog2(RES_ROWS) : 1;
  localparam int CW = (RES_COLS > 1) ? $clog2(RES_COLS) : 1;
  localparam int RDW = 2 * DATA_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ACK, S_RUN, S_CHECK, S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    lcnt_q, lcnt_d;
  logic [15:0]   tmr_q, tmr_d;
  logic          ph_q, ph_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [7:0]    err_q, err_d;
  logic          to_q, to_d;
  logic          pass_q, pass_d;
  logic          done_q, done_d;
  logic          lp_q, lp_d;
  logic          sc_q, sc_d;
  logic          busy_q, busy_d;
`ifdef SEQ_FIRST_ERR_EN
  logic           fev_q, fev_d;
  logic [RW-1:0]  fer_q, fer_d;
  logic [CW-1:0]  fec_q, fec_d;
  logic [RDW-1:0] fed_q, fed_d;
`endif

  logic mism;
  logic last_el;
  logic last_col;
  logic tmr_end;

  assign mism     = bus.res_data != bus.exp_data;
  assign last_col = col_q == CW'(RES_COLS - 1);
  assign last_el  = last_col && (row_q == RW'(RES_ROWS - 1));
  assign tmr_end  = tmr_q == 16'(TIMEOUT - 1);

  always_comb begin
    state_d = state_q;
    lcnt_d  = lcnt_q;
    tmr_d   = tmr_q;
    ph_d    = ph_q;
    row_d   = row_q;
    col_d   = col_q;
    err_d   = err_q;
    to_d    = to_q;
    pass_d  = pass_q;
`ifdef SEQ_FIRST_ERR_EN
    fev_d = fev_q;
    fer_d = fer_q;
    fec_d = fec_q;
    fed_d = fed_q;
`endif
    if (bus.abort) begin
      state_d = S_IDLE;
      lcnt_d  = '0;
      tmr_d   = '0;
      ph_d    = 1'b0;
      row_d   = '0;
      col_d   = '0;
      err_d   = '0;
      to_d    = 1'b0;
      pass_d  = 1'b0;
`ifdef SEQ_FIRST_ERR_EN
      fev_d = 1'b0;
      fer_d = '0;
      fec_d = '0;
      fed_d = '0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.go) begin
            state_d = S_LOAD;
            lcnt_d  = '0;
            ph_d    = 1'b0;
            row_d   = '0;
            col_d   = '0;
            err_d   = '0;
            to_d    = 1'b0;
            pass_d  = 1'b0;
`ifdef SEQ_FIRST_ERR_EN
            fev_d = 1'b0;
            fer_d = '0;
            fec_d = '0;
            fed_d = '0;
`endif
          end
        end
        S_LOAD: begin
          if (lcnt_q == 8'(LOAD_CYCLES - 1)) begin
            state_d = S_ACK;
            tmr_d   = '0;
          end else begin
            lcnt_d = lcnt_q + 8'd1;
          end
        end
        S_ACK: begin
          // Progress wins over a timeout landing on the same cycle
          if (!bus.ready) begin
            state_d = S_RUN;
            tmr_d   = '0;
          end else if (tmr_end) begin
            state_d = S_DONE;
            to_d    = 1'b1;
            pass_d  = 1'b0;
          end else begin
            tmr_d = tmr_q + 16'd1;
          end
        end
        S_RUN: begin
          if (bus.ready) begin
            state_d = S_CHECK;
            ph_d    = 1'b0;
          end else if (tmr_end) begin
            state_d = S_DONE;
            to_d    = 1'b1;
            pass_d  = 1'b0;
          end else begin
            tmr_d = tmr_q + 16'd1;
          end
        end
        S_CHECK: begin
          ph_d = ~ph_q;
          if (ph_q) begin
            if (mism && err_q != 8'hFF) err_d = err_q + 8'd1;
`ifdef SEQ_FIRST_ERR_EN
            if (mism && !fev_q) begin
              fev_d = 1'b1;
              fer_d = row_q;
              fec_d = col_q;
              fed_d = bus.res_data;
            end
`endif
            if (last_el) begin
              state_d = S_DONE;
              pass_d  = (err_d == 8'd0) && !to_q;
            end else if (last_col) begin
              col_d = '0;
              row_d = row_q + RW'(1);
            end else begin
              col_d = col_q + CW'(1);
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    done_d = (state_d == S_DONE) && (state_q != S_DONE);
    lp_d   = state_d == S_LOAD;
    sc_d   = state_d == S_ACK;
    busy_d = !(state_d inside {S_IDLE, S_DONE});
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      lcnt_q  <= '0;
      tmr_q   <= '0;
      ph_q    <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
      err_q   <= '0;
      to_q    <= 1'b0;
      pass_q  <= 1'b0;
      done_q  <= 1'b0;
      lp_q    <= 1'b0;
      sc_q    <= 1'b0;
      busy_q  <= 1'b0;
`ifdef SEQ_FIRST_ERR_EN
      fev_q <= 1'b0;
      fer_q <= '0;
      fec_q <= '0;
      fed_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      lcnt_q  <= lcnt_d;
      tmr_q   <= tmr_d;
      ph_q    <= ph_d;
      row_q   <= row_d;
      col_q   <= col_d;
      err_q   <= err_d;
      to_q    <= to_d;
      pass_q  <= pass_d;
      done_q  <= done_d;
      lp_q    <= lp_d;
      sc_q    <= sc_d;
      busy_q  <= busy_d;
`ifdef SEQ_FIRST_ERR_EN
      fev_q <= fev_d;
      fer_q <= fer_d;
      fec_q <= fec_d;
      fed_q <= fed_d;
`endif
    end
  end

  assign bus.load_params = lp_q;
  assign bus.start_comp  = sc_q;
  assign bus.res_row     = row_q;
  assign bus.res_col     = col_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.pass        = pass_q;
  assign bus.err_count   = err_q;
  assign bus.timeout     = to_q;
`ifdef SEQ_FIRST_ERR_EN
  assign bus.first_err_valid = fev_q;
  assign bus.first_err_row   = fer_q;
  assign bus.first_err_col   = fec_q;
  assign bus.first_err_data  = fed_q;
`endif
endmodule

// File: tb/tb_sys_array_sequencer.sv
// Bench: timeline model of a 2x2 sequencer checked every cycle,
// plus directed runs on an 18x18 instance with TIMEOUT=16.
module tb_sys_array_sequencer;
  localparam int DW = 8;
  localparam int L  = 4;
  localparam int R  = 2;
  localparam int C  = 2;
  localparam int N2 = 18 * 18;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  sys_array_sequencer_if #(.DATA_WIDTH(DW), .RES_ROWS(R),
    .RES_COLS(C)) b1();
  sys_array_sequencer_if #(.DATA_WIDTH(DW), .RES_ROWS(18),
    .RES_COLS(18)) b2();

  sys_array_sequencer #(.DATA_WIDTH(DW), .RES_ROWS(R),
    .RES_COLS(C), .LOAD_CYCLES(L), .TIMEOUT(1023)) u1 (
    .clk(clk), .reset_n(reset_n), .bus(b1));
  sys_array_sequencer #(.DATA_WIDTH(DW), .RES_ROWS(18),
    .RES_COLS(18), .LOAD_CYCLES(L), .TIMEOUT(16)) u2 (
    .clk(clk), .reset_n(reset_n), .bus(b2));

  logic [15:0] r1 [R*C];
  logic [15:0] e1 [R*C];
  logic [15:0] r2 [N2];
  logic [15:0] e2 [N2];

  assign b1.res_data = r1[int'(b1.res_row) * C + int'(b1.res_col)];
  assign b1.exp_data = e1[int'(b1.res_row) * C + int'(b1.res_col)];
  assign b2.res_data = r2[int'(b2.res_row) * 18 + int'(b2.res_col)];
  assign b2.exp_data = e2[int'(b2.res_row) * 18 + int'(b2.res_col)];

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  bit cmp_en = 0;

  // current run plan for DUT 1
  int p_act = 0;
  int p_gc = 0;
  int p_a = 0;
  int p_r = 0;
  int p_ab = -1;

  int lp_cnt = 0;
  int busy_cnt = 0;
  int done_cnt = 0;

  typedef struct packed {
    logic lp, sc, busy, done, pass, to;
    logic [7:0] err;
    logic row, col;
  } obs_t;

  task automatic chk(input string name, input longint act,
                     input longint req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  function automatic int mism_upto(input int n);
    int m = 0;
    for (int e = 0; e < n; e++) if (r1[e] != e1[e]) m++;
    return m;
  endfunction

  function automatic logic [7:0] sat(input int x);
    return (x > 255) ? 8'd255 : 8'(x);
  endfunction

  // Expected DUT1 outputs in cycle c from the phase lengths of the run
  function automatic obs_t model(input int c);
    obs_t o;
    int t;
    int nck;
    int e;
    int tot;
    o = '0;
    if (p_act == 0 || c <= p_gc) return o;
    if (p_ab >= 0 && c >= p_ab) return o;
    t = c - p_gc - 1;
    if (t < L) begin o.lp = 1; o.busy = 1; return o; end
    t -= L;
    if (t < p_a) begin o.sc = 1; o.busy = 1; return o; end
    t -= p_a;
    if (t < p_r) begin o.busy = 1; return o; end
    t -= p_r;
    nck = 2 * R * C;
    if (t < nck) begin
      e = t / 2;
      o.busy = 1;
      o.row = 1'(e / C);
      o.col = 1'(e % C);
      o.err = sat(mism_upto(t / 2));
      return o;
    end
    tot = mism_upto(R * C);
    o.done = (t == nck);
    o.row = 1'(R - 1);
    o.col = 1'(C - 1);
    o.err = sat(tot);
    o.pass = (tot == 0);
    return o;
  endfunction

  always @(posedge clk) begin
    obs_t a;
    obs_t x;
    cyc++;
    #1;
    if (cmp_en) begin
      a = {b1.load_params, b1.start_comp, b1.busy, b1.done,
           b1.pass, b1.timeout, b1.err_count,
           b1.res_row, b1.res_col};
      x = model(cyc);
      n_chk++;
      if (a === x) n_pass++;
      else $display("FAIL cycle_%0d outputs: got %h, expected %h",
                    cyc, a, x);
    end
  end

  always @(posedge clk) begin
    #2;
    if (b1.load_params) lp_cnt++;
    if (b1.busy) busy_cnt++;
    if (b1.done) done_cnt++;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_go(input int s, input logic v);
    if (s == 1) b1.go = v; else b2.go = v;
  endtask

  task automatic set_ready(input int s, input logic v);
    if (s == 1) b1.ready = v; else b2.ready = v;
  endtask

  task automatic set_abort(input int s, input logic v);
    if (s == 1) b1.abort = v; else b2.abort = v;
  endtask

  function automatic logic get_sc(input int s);
    return (s == 1) ? b1.start_comp : b2.start_comp;
  endfunction

  function automatic logic get_done(input int s);
    return (s == 1) ? b1.done : b2.done;
  endfunction

  // Fetcher: ready falls drop cycles after start_comp, rises hold later
  task automatic do_run(input int s, input int drop, input int hold,
                        input bit never, input bit go_mid,
                        input int abort_k, output int g,
                        output int sc_c, output int d);
    int n;
    int k;
    g = cyc;
    sc_c = -1;
    d = -1;
    if (s == 1) begin
      p_act = 1; p_gc = cyc; p_a = drop + 1; p_r = hold; p_ab = -1;
      lp_cnt = 0; busy_cnt = 0; done_cnt = 0;
    end
    set_go(s, 1'b1);
    tick();
    set_go(s, 1'b0);
    n = 0;
    while (!get_sc(s) && n < 50) begin tick(); n++; end
    if (!get_sc(s)) begin
      chk("start_comp_wait", 0, 1);
      return;
    end
    sc_c = cyc;
    if (!never) begin
      repeat (drop) tick();
      set_ready(s, 1'b0);
      k = 0;
      while (k < hold || (abort_k > 0 && k < abort_k)) begin
        tick();
        k++;
        if (k == hold) set_ready(s, 1'b1);
        if (go_mid) set_go(s, (k == hold / 2) ? 1'b1 : 1'b0);
        if (k == abort_k) begin
          set_abort(s, 1'b1);
          set_ready(s, 1'b1);
          if (s == 1) p_ab = cyc + 1;
          tick();
          set_abort(s, 1'b0);
          return;
        end
      end
    end
    n = 0;
    while (!get_done(s) && n < 2000) begin tick(); n++; end
    if (!get_done(s)) chk("done_wait", 0, 1);
    else d = cyc;
  endtask

  int g, sc, d;

  initial begin
    b1.go = 0; b1.abort = 0; b1.ready = 1;
    b2.go = 0; b2.abort = 0; b2.ready = 1;
    e1[0] = 16'h1234; e1[1] = 16'h00ff;
    e1[2] = 16'habcd; e1[3] = 16'h8001;
    for (int i = 0; i < R * C; i++) r1[i] = e1[i];
    for (int i = 0; i < N2; i++) begin
      e2[i] = 16'(i);
      r2[i] = 16'(i);
    end
    tick();
    cmp_en = 1;
    tick();
    tick();
    reset_n = 1'b1;
    chk("reset_busy", b1.busy, 0);
    chk("reset_err", b1.err_count, 0);
    chk("reset_row2", b2.res_row, 0);
    tick();
    tick();

    // golden run
    do_run(1, 3, 20, 0, 0, -1, g, sc, d);
    chk("golden_ack_offset", sc - g, 5);
    chk("golden_done_offset", d - g, 37);
    chk("golden_pass", b1.pass, 1);
    chk("golden_err", b1.err_count, 0);
    chk("golden_lp_cycles", lp_cnt, 4);
    chk("golden_busy_cycles", busy_cnt, 36);
    repeat (3) tick();
    chk("golden_done_pulses", done_cnt, 1);
    chk("golden_pass_held", b1.pass, 1);

    // mismatch at [1][0], then back-to-back golden
    r1[2] = e1[2] ^ 16'h0001;
    do_run(1, 3, 20, 0, 0, -1, g, sc, d);
    chk("mism_done_offset", d - g, 37);
    chk("mism_err", b1.err_count, 1);
    chk("mism_pass", b1.pass, 0);
`ifdef SEQ_FIRST_ERR_EN
    chk("first_err_valid", b1.first_err_valid, 1);
    chk("first_err_row", b1.first_err_row, 1);
    chk("first_err_col", b1.first_err_col, 0);
    chk("first_err_data", b1.first_err_data, 16'habcc);
`endif
    r1[2] = e1[2];
    do_run(1, 3, 20, 0, 0, -1, g, sc, d);
    chk("b2b_done_offset", d - g, 37);
    chk("b2b_err", b1.err_count, 0);
    chk("b2b_pass", b1.pass, 1);
    repeat (3) tick();

    // go pulsed mid-RUN must not restart the run
    do_run(1, 3, 20, 0, 1, -1, g, sc, d);
    chk("gomid_done_offset", d - g, 37);
    repeat (3) tick();
    chk("gomid_done_pulses", done_cnt, 1);

    // abort in RUN, then a normal run
    do_run(1, 3, 20, 0, 0, 10, g, sc, d);
    chk("abort_busy", b1.busy, 0);
    chk("abort_start_comp", b1.start_comp, 0);
    chk("abort_err", b1.err_count, 0);
    repeat (2) tick();
    do_run(1, 3, 20, 0, 0, -1, g, sc, d);
    chk("after_abort_done_offset", d - g, 37);
    chk("after_abort_pass", b1.pass, 1);
    repeat (2) tick();

    // abort in CHECK after a mismatch has been counted
    r1[2] = e1[2] ^ 16'h0100;
    do_run(1, 3, 20, 0, 0, 27, g, sc, d);
    chk("abort_check_err", b1.err_count, 0);
    chk("abort_check_pass", b1.pass, 0);
    r1[2] = e1[2];
    repeat (2) tick();

    // 18x18: 300 forced mismatches saturate the count
    for (int i = 0; i < 300; i++) r2[i] = ~16'(i);
    do_run(2, 3, 5, 0, 0, -1, g, sc, d);
    chk("sat_done_offset", d - g, 662);
    chk("sat_err", b2.err_count, 255);
    chk("sat_pass", b2.pass, 0);
    chk("sat_row", b2.res_row, 17);
    chk("sat_col", b2.res_col, 17);
    chk("sat_timeout", b2.timeout, 0);
    repeat (2) tick();

    // fetcher never drops ready: ACK times out after 16 cycles
    for (int i = 0; i < 300; i++) r2[i] = 16'(i);
    do_run(2, 0, 0, 1, 0, -1, g, sc, d);
    chk("to_done_after_ack", d - sc, 16);
    chk("to_timeout", b2.timeout, 1);
    chk("to_pass", b2.pass, 0);
    chk("to_err", b2.err_count, 0);
    chk("to_row", b2.res_row, 0);
    chk("to_col", b2.res_col, 0);
    chk("to_busy", b2.busy, 0);
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
